life_meter: RTL and testbench

Parametrised lives indicator for the VGA pong display. It owns the player's life count and the matching row of heart icons, and it blinks the icon of a life just lost for a fixed number of frames. It fetches pixel colour from one shared external synchronous heart ROM and feeds the pixel mux in the same slot as the other sprite generators. It raises `game_over` once the last life is gone and its blink has finished.

---
 rtl/life_meter.sv | 135 +++++++++++++
 tb/tb_life_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/life_meter.sv
// Lives indicator for the pong display: owns the life count, draws a row of heart icons
// and blinks the icon of a life just lost. Pixel colour comes from a shared external ROM.
module life_meter #(
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned ORIGIN_X      = 512,
  parameter int unsigned ORIGIN_Y      = 30,
  parameter int unsigned ICON_W        = 24,
  parameter int unsigned ICON_H        = 24,
  parameter int unsigned PITCH         = 36,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter int unsigned BLINK_TOGGLES = 6,
  localparam int unsigned LW           = $clog2(MAX_LIVES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          life_lost,
  input  logic          game_restart,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [4:0]    rom_row,
  output logic [4:0]    rom_col,
  input  logic [11:0]   rom_data,
  output logic [11:0]   rgb,
  output logic          heart_on,
  output logic [LW-1:0] lives,
  output logic          game_over
);

  localparam int unsigned FW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
  localparam logic [FW-1:0] FrameLast = FW'(BLINK_PERIOD - 1);
  localparam logic [TW-1:0] TogLast   = TW'(BLINK_TOGGLES - 1);
  localparam logic [LW-1:0] LivesFull = LW'(MAX_LIVES);

  typedef enum logic [0:0] {StIdle, StBlink} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [LW-1:0] blink_idx_q, blink_idx_d;
  logic          phase_q, phase_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] tog_cnt_q, tog_cnt_d;
  logic          heart_on_q, hit;
  logic          game_over_q, game_over_d;

  int unsigned   xi, yi;
  logic          in_y;

  // Pixel hit test and ROM addressing
  always_comb begin
    xi      = 32'(x);
    yi      = 32'(y);
    in_y    = (yi >= ORIGIN_Y) && (yi < ORIGIN_Y + ICON_H);
    rom_row = 5'(yi - ORIGIN_Y);
    rom_col = 5'(xi - ORIGIN_X);
    hit     = 1'b0;
    for (int unsigned i = 0; i < MAX_LIVES; i++) begin
      if (in_y && (xi >= ORIGIN_X + i * PITCH) && (xi < ORIGIN_X + i * PITCH + ICON_W) &&
          ((i < 32'(lives_q)) ||
           ((state_q == StBlink) && (i == 32'(blink_idx_q)) && phase_q))) begin
        hit     = 1'b1;
        rom_col = 5'(xi - (ORIGIN_X + i * PITCH));
      end
    end
  end

  // Life count and blink sequencing; restart beats a loss, a loss beats a tick
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    blink_idx_d = blink_idx_q;
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    game_over_d = (lives_q == '0) && (state_q == StIdle);
    if (game_restart) begin
      state_d     = StIdle;
      lives_d     = LivesFull;
      blink_idx_d = '0;
      phase_d     = 1'b0;
      frame_cnt_d = '0;
      tog_cnt_d   = '0;
    end else if (life_lost && (lives_q != '0)) begin
      state_d     = StBlink;
      lives_d     = lives_q - LW'(1);
      blink_idx_d = lives_q - LW'(1);
      phase_d     = 1'b1;
      frame_cnt_d = '0;
      tog_cnt_d   = '0;
    end else if ((state_q == StBlink) && frame_tick) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        if (tog_cnt_q == TogLast) begin
          state_d   = StIdle;
          phase_d   = 1'b0;
          tog_cnt_d = '0;
        end else begin
          phase_d   = ~phase_q;
          tog_cnt_d = tog_cnt_q + TW'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      lives_q     <= LivesFull;
      blink_idx_q <= '0;
      phase_q     <= 1'b0;
      frame_cnt_q <= '0;
      tog_cnt_q   <= '0;
      heart_on_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      blink_idx_q <= blink_idx_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      heart_on_q  <= hit;
      game_over_q <= game_over_d;
    end
  end

  assign heart_on  = heart_on_q;
  assign rgb       = heart_on_q ? rom_data : 12'h000;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_life_meter.sv
// Directed bench for life_meter: default instance plus a five-life contiguous variant.
module tb_life_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, life_lost, game_restart;
  logic [9:0]  x, y;
  logic [4:0]  rom_row, rom_col;
  logic [11:0] rom_data, rgb;
  logic        heart_on, game_over;
  logic [1:0]  lives;

  logic        life_lost5, restart5;
  logic [4:0]  rom_row5, rom_col5;
  logic [11:0] rgb5;
  logic        heart_on5, game_over5;
  logic [2:0]  lives5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  life_meter u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .life_lost(life_lost),
    .game_restart(game_restart), .x(x), .y(y), .rom_row(rom_row), .rom_col(rom_col),
    .rom_data(rom_data), .rgb(rgb), .heart_on(heart_on), .lives(lives), .game_over(game_over)
  );

  life_meter #(.MAX_LIVES(5), .PITCH(24)) u_dut5 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .life_lost(life_lost5),
    .game_restart(restart5), .x(x), .y(y), .rom_row(rom_row5), .rom_col(rom_col5),
    .rom_data(rom_data), .rgb(rgb5), .heart_on(heart_on5), .lives(lives5),
    .game_over(game_over5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel, wait one cycle, check the registered flag and the colour mux
  task automatic pix(input string tag, input int xv, input int yv, input logic exp);
    logic [11:0] d;
    x = 10'(xv);
    y = 10'(yv);
    cyc();
    d = 12'($urandom_range(1, 4095));
    rom_data = d;
    #1;
    check({tag, "_on"}, 32'(heart_on), 32'(exp));
    check({tag, "_rgb"}, 32'(rgb), exp ? 32'(d) : 32'h0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic lose();
    life_lost = 1'b1;
    cyc();
    life_lost = 1'b0;
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; life_lost = 1'b0; game_restart = 1'b0;
    life_lost5 = 1'b0; restart5 = 1'b0;
    x = 10'd512; y = 10'd30; rom_data = 12'hFFF;
    repeat (3) cyc();
    check("rst_on", 32'(heart_on), 32'h0);
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_go", 32'(game_over), 32'h0);
    check("rst_lives5", 32'(lives5), 32'd5);
    rst = 1'b1;
    cyc();

    // Default frame geometry and boundaries
    x = 10'd512; y = 10'd30; #1;
    check("addr0_row", 32'(rom_row), 32'd0);
    check("addr0_col", 32'(rom_col), 32'd0);
    x = 10'd560; y = 10'd40; #1;
    check("addr1_row", 32'(rom_row), 32'd10);
    check("addr1_col", 32'(rom_col), 32'd12);
    pix("p512_30", 512, 30, 1'b1);
    pix("p535_53", 535, 53, 1'b1);
    pix("p536", 536, 30, 1'b0);
    pix("p547", 547, 30, 1'b0);
    pix("p548", 548, 40, 1'b1);
    pix("p584", 584, 30, 1'b1);
    pix("p607_53", 607, 53, 1'b1);
    pix("p608", 608, 30, 1'b0);
    pix("p511", 511, 30, 1'b0);
    pix("py29", 520, 29, 1'b0);
    pix("py54", 520, 54, 1'b0);
    check("idle_go", 32'(game_over), 32'h0);

    // Single loss: icon 2 blinks for 48 ticks then stays hidden
    x = 10'd590; y = 10'd35;
    lose();
    check("l1_lives", 32'(lives), 32'd2);
    cyc();
    check("bl_t0", 32'(heart_on), 32'h1);
    frames(7);  check("bl_t7", 32'(heart_on), 32'h1);
    frames(1);  check("bl_t8", 32'(heart_on), 32'h0);
    frames(8);  check("bl_t16", 32'(heart_on), 32'h1);
    frames(8);  check("bl_t24", 32'(heart_on), 32'h0);
    frames(15); check("bl_t39", 32'(heart_on), 32'h1);
    frames(8);  check("bl_t47", 32'(heart_on), 32'h0);
    frames(1);  check("bl_t48", 32'(heart_on), 32'h0);
    frames(8);  check("bl_t56", 32'(heart_on), 32'h0);
    check("bl_lives", 32'(lives), 32'd2);
    check("bl_go", 32'(game_over), 32'h0);
    pix("bl_icon1", 560, 35, 1'b1);

    // Three losses ten ticks apart, ending in game over
    game_restart = 1'b1; cyc(); game_restart = 1'b0;
    check("rs1_lives", 32'(lives), 32'd3);
    x = 10'd590; y = 10'd35;
    lose(); cyc();
    check("m1_icon2", 32'(heart_on), 32'h1);
    frames(10);
    check("m1_t10", 32'(heart_on), 32'h0);
    lose();
    check("m2_lives", 32'(lives), 32'd1);
    cyc();
    check("m2_icon2", 32'(heart_on), 32'h0);
    pix("m2_icon1", 560, 35, 1'b1);
    frames(10);
    check("m2_t10", 32'(heart_on), 32'h0);
    lose();
    check("m3_lives", 32'(lives), 32'd0);
    pix("m3_icon0", 524, 35, 1'b1);
    check("m3_go", 32'(game_over), 32'h0);
    frames(47);
    check("m3_t47_go", 32'(game_over), 32'h0);
    check("m3_t47_on", 32'(heart_on), 32'h0);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    check("go_edge", 32'(game_over), 32'h0);
    cyc();
    check("go_rise", 32'(game_over), 32'h1);
    check("go_on", 32'(heart_on), 32'h0);
    lose();
    check("l4_lives", 32'(lives), 32'd0);
    cyc();
    check("l4_go", 32'(game_over), 32'h1);

    // Restart clears game over; restart beats a simultaneous loss
    game_restart = 1'b1; cyc(); game_restart = 1'b0;
    cyc();
    check("rs2_lives", 32'(lives), 32'd3);
    check("rs2_go", 32'(game_over), 32'h0);
    lose(); lose();
    check("pr_lives1", 32'(lives), 32'd1);
    x = 10'd560; y = 10'd35;
    cyc();
    check("pr_blink", 32'(heart_on), 32'h1);
    game_restart = 1'b1; life_lost = 1'b1;
    cyc();
    game_restart = 1'b0; life_lost = 1'b0;
    check("pr_lives", 32'(lives), 32'd3);
    frames(8);
    check("pr_icon1", 32'(heart_on), 32'h1);
    pix("pr_icon2", 590, 35, 1'b1);
    check("pr_lives_b", 32'(lives), 32'd3);

    // Five contiguous icons
    x = 10'd631; y = 10'd30; #1;
    check("f5_col", 32'(rom_col5), 32'd23);
    cyc();
    check("f5_p631", 32'(heart_on5), 32'h1);
    x = 10'd632; cyc();
    check("f5_p632", 32'(heart_on5), 32'h0);
    x = 10'd536; cyc();
    check("f5_p536", 32'(heart_on5), 32'h1);
    for (int k = 4; k >= 0; k--) begin
      life_lost5 = 1'b1; cyc(); life_lost5 = 1'b0;
      check("f5_count", 32'(lives5), 32'(k));
    end
    life_lost5 = 1'b1; cyc(); life_lost5 = 1'b0;
    check("f5_nowrap", 32'(lives5), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
